// File: rtl/i2c_write_engine.sv
// I2C master write engine: START, three bytes {dev_addr,0}/reg_addr/data, STOP.
// Params: CLK_DIV (clocks per quarter bit, 1..65535).
// Ports: clock, reset (sync, active-high), start, dev_addr[6:0],
//   reg_addr[7:0], data[7:0], sda_in -> scl (1=released), sda_oe (1=pull low),
//   idle, cl_high (strobe at start of SCL-high half-bit), ack_error (sticky NACK).
// Macro I2C_ACK_CHECK_EN: sample ACK on sda_in, abort to STOP on NACK.
module i2c_write_engine #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       idle,
  output logic       cl_high,
  output logic       ack_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  phase_q, phase_d;
  logic [1:0]  byte_q, byte_d;
  logic [2:0]  bit_q, bit_d;
  logic [23:0] bytes_q, bytes_d;
  logic        cl_high_q, cl_high_d;
  logic        q;
  logic        accept;
  logic        period_end;
  logic        nack;
  logic [7:0]  cur_byte;

`ifdef I2C_ACK_CHECK_EN
  logic ack_error_q, ack_error_d;
  assign nack      = ack_error_q;
  assign ack_error = ack_error_q;
`else
  logic sda_in_unused;
  assign sda_in_unused = sda_in;
  assign nack          = 1'b0;
  assign ack_error     = 1'b0;
`endif

  assign q          = (div_q == DIV_LAST);
  assign accept     = (state_q == S_IDLE) && start;
  assign period_end = q && (phase_q == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      bytes_q   <= '0;
      cl_high_q <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
      ack_error_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      bytes_q   <= bytes_d;
      cl_high_q <= cl_high_d;
`ifdef I2C_ACK_CHECK_EN
      ack_error_q <= ack_error_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = q ? 16'd0 : div_q + 16'd1;
    phase_d   = q ? phase_q + 2'd1 : phase_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    bytes_d   = bytes_q;
    cl_high_d = q && (phase_q == 2'd1);
`ifdef I2C_ACK_CHECK_EN
    ack_error_d = ack_error_q;
    if (state_q == S_ACK && q && phase_q == 2'd2 && sda_in)
      ack_error_d = 1'b1;
`endif
    if (accept) begin
      // Realign the bit clock so START gets a full period.
      state_d   = S_START;
      div_d     = '0;
      phase_d   = '0;
      byte_d    = '0;
      bit_d     = 3'd7;
      bytes_d   = {dev_addr, 1'b0, reg_addr, data};
      cl_high_d = 1'b0;
`ifdef I2C_ACK_CHECK_EN
      ack_error_d = 1'b0;
`endif
    end else if (period_end) begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_START: begin
          state_d = S_BIT;
          bit_d   = 3'd7;
        end
        S_BIT: begin
          if (bit_q == 3'd0) state_d = S_ACK;
          else bit_d = bit_q - 3'd1;
        end
        S_ACK: begin
          if (nack || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BIT;
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
          end
        end
        S_STOP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    unique case (1'b1)
      (byte_q == 2'd0): cur_byte = bytes_q[23:16];
      (byte_q == 2'd1): cur_byte = bytes_q[15:8];
      default:          cur_byte = bytes_q[7:0];
    endcase
  end

  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    idle   = (state_q == S_IDLE);
    unique case (state_q)
      S_IDLE:  ;
      S_START: sda_oe = phase_q[1];
      S_BIT: begin
        scl    = phase_q[1];
        sda_oe = ~cur_byte[bit_q];
      end
      S_ACK:   scl = phase_q[1];
      S_STOP: begin
        scl    = (phase_q != 2'd0);
        sda_oe = (phase_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign cl_high = cl_high_q;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Randomized bench for i2c_write_engine with a per-cycle bus reference model.
// Runs with CLK_DIV=2 (8-clock bit period).
module tb_i2c_write_engine;

  localparam int DIV = 2;
  localparam int PER = 4 * DIV;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] data;
  logic       sda_in;
  logic       scl;
  logic       sda_oe;
  logic       idle;
  logic       cl_high;
  logic       ack_error;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_write_engine #(.CLK_DIV(DIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dev_addr  (dev_addr),
    .reg_addr  (reg_addr),
    .data      (data),
    .sda_in    (sda_in),
    .scl       (scl),
    .sda_oe    (sda_oe),
    .idle      (idle),
    .cl_high   (cl_high),
    .ack_error (ack_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {scl, sda_oe, idle, cl_high} for clock i after acceptance
  // of a transfer spanning n bit periods carrying bytes b.
  function automatic logic [3:0] exp_bus(input int i, input int n,
                                         input logic [23:0] b);
    int p, ph, k, bi, bt;
    logic s, o, c;
    p  = i / PER;
    ph = (i % PER) / DIV;
    c  = ((i % PER) == 2 * DIV);
    if (p == 0) begin
      s = 1'b1;
      o = (ph >= 2);
    end else if (p == n - 1) begin
      s = (ph != 0);
      o = (ph != 3);
    end else begin
      k  = p - 1;
      bi = k / 9;
      bt = k % 9;
      s  = (ph >= 2);
      if (bt == 8) o = 1'b0;
      else o = ~b[23 - bi * 8 - bt];
    end
    return {s, o, 1'b0, c};
  endfunction

  task automatic txn(input logic [6:0] d, input logic [7:0] r,
                     input logic [7:0] v, input bit nack, input int mid);
    logic [23:0] b;
    int n;
    logic exp_ack;
    b       = {d, 1'b0, r, v};
    n       = 29;
    exp_ack = 1'b0;
`ifdef I2C_ACK_CHECK_EN
    if (nack) begin
      n       = 11;
      exp_ack = 1'b1;
    end
`endif
    sda_in   = nack;
    dev_addr = d;
    reg_addr = r;
    data     = v;
    start    = 1'b1;
    @(negedge clock);
    check("pre_idle", idle, 1);
    @(posedge clock);
    #1;
    start    = 1'b0;
    dev_addr = 7'($urandom);
    reg_addr = 8'($urandom);
    data     = 8'($urandom);
    for (int i = 0; i < n * PER; i++) begin
      start = (i == mid) || (i == n * PER - 1);
      @(negedge clock);
      check("bus", {scl, sda_oe, idle, cl_high}, exp_bus(i, n, b));
      @(posedge clock);
      #1;
    end
    start  = 1'b0;
    sda_in = 1'b0;
    @(negedge clock);
    check("end_idle", {scl, sda_oe, idle}, 3'b101);
    check("ack_err", ack_error, exp_ack);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("stay_idle", {scl, sda_oe, idle}, 3'b101);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic abort_txn(input logic [6:0] d, input logic [7:0] r,
                           input logic [7:0] v);
    logic [23:0] b;
    b        = {d, 1'b0, r, v};
    sda_in   = 1'b0;
    dev_addr = d;
    reg_addr = r;
    data     = v;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      check("abort_pre", {scl, sda_oe, idle, cl_high}, exp_bus(i, 29, b));
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_rel", {scl, sda_oe, idle, cl_high, ack_error}, 5'b10100);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("abort_nostop", {scl, sda_oe, idle}, 3'b101);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    start    = 1'b0;
    dev_addr = '0;
    reg_addr = '0;
    data     = '0;
    sda_in   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_state", {scl, sda_oe, idle, cl_high, ack_error}, 5'b10100);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i != 0) @(negedge clock);
      check("idle_cl", cl_high, ((i % PER) == 2 * DIV));
      cnt += int'(cl_high);
    end
    check("idle_cl_cnt", cnt, 5);
    @(posedge clock);
    #1;

    txn(7'h3C, 8'h10, 8'hA5, 1'b0, 50);
    txn(7'h3C, 8'h10, 8'hA5, 1'b1, 50);
    txn(7'h51, 8'hFF, 8'h00, 1'b0, 120);
    abort_txn(7'h2A, 8'h5A, 8'hC3);

    for (int t = 0; t < 5; t++) begin
      int gap;
      gap = int'($urandom_range(0, 10));
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        check("gap_idle", {scl, sda_oe, idle}, 3'b101);
        @(posedge clock);
        #1;
      end
      txn(7'($urandom), 8'($urandom), 8'($urandom),
          ($urandom_range(0, 3) == 0), int'($urandom_range(8, 80)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_write_engine.md
I2C_WRITE_ENGINE -- requirements
Module: i2c_write_engine

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, clock cycles per quarter SCL bit period; legal range 1..65535.
REQ-002 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  transaction request, sampled every cycle.
REQ-005 SHALL have port dev_addr  input  7  target 7-bit device address.
REQ-006 SHALL have port reg_addr  input  8  target register address.
REQ-007 SHALL have port data  input  8  byte to write.
REQ-008 SHALL have port sda_in  input  1  sampled SDA line level.
REQ-009 SHALL have port scl  output  1  SCL drive, where 1 means released (high) and 0 means driven low.
REQ-010 SHALL have port sda_oe  output  1  open-drain SDA pull-low enable, where 1 pulls SDA low.
REQ-011 SHALL have port idle  output  1  engine is in IDLE and accepts start.
REQ-012 SHALL have port cl_high  output  1  one-cycle strobe at the start of each SCL-high half-bit.
REQ-013 SHALL have port ack_error  output  1  sticky NACK flag for the last transaction.

Function
REQ-014 SHALL run a free-running 16-bit divider producing a tick q every CLK_DIV clocks, plus a 2-bit phase counter (0..3) advancing on each q; one bit period equals 4*CLK_DIV clocks.
REQ-015 SHALL drive cl_high high for exactly one clock on each q that enters phase 2, in every state including IDLE, so that one strobe occurs per bit period.
REQ-016 SHALL implement states IDLE, START, BIT, ACK and STOP; each non-IDLE state lasts one bit period, and transitions occur on the q that ends phase 3.
REQ-017 SHALL accept a transaction in IDLE when start=1: latch the byte sequence {dev_addr,0}, reg_addr, data; clear ack_error; reset the divider and phase to 0; and enter START on the next clock.
REQ-018 SHALL ignore start outside IDLE, and SHALL ignore changes to the input fields after acceptance.
REQ-019 SHALL drive the following per-phase waveform, listed as phases 0..3, where a "1" on SDA means sda_oe=0:
- START: SCL 1,1,1,1 and SDA 1,1,0,0.
- BIT: SCL 0,0,1,1 and SDA equal to the current bit for all four phases, MSB first.
- ACK: SCL 0,0,1,1 with sda_oe=0.
- STOP: SCL 0,1,1,1 and SDA 0,0,0,1.
REQ-020 SHALL sequence START, then 3 x (8 BIT + 1 ACK), then STOP, then IDLE, for a total of 29 bit periods, using a 2-bit byte counter (0..2) and a 3-bit bit counter (7..0).
REQ-021 SHALL deassert idle on the clock after acceptance and reassert it on the clock after STOP ends; a start coincident with that final STOP tick SHALL be ignored.
REQ-022 SHALL drive scl=1, sda_oe=0 and idle=1 while in IDLE.

Reset
REQ-023 SHALL, on reset, set the state to IDLE and clear the divider, phase, byte and bit counters, with scl=1, sda_oe=0, idle=1, cl_high=0 and ack_error=0 on the following clock.
REQ-024 SHALL abort a transaction in progress immediately on reset without generating STOP; the bus SHALL be released on the next clock.

Configuration
REQ-025 SHALL provide macro I2C_ACK_CHECK_EN; when it is defined, the engine SHALL sample sda_in on the q ending ACK phase 2, and a value of 1 (NACK) SHALL set ack_error and proceed directly to STOP after that ACK bit.
REQ-026 SHALL, when I2C_ACK_CHECK_EN is undefined, ignore sda_in, tie ack_error to 0, and always send all three bytes.

Verification (CLK_DIV=2, bit period 8 clocks)
REQ-027 SHALL cover a write of dev 0x3C, reg 0x10, data 0xA5 with ACK held low -> SDA bytes 0x78, 0x10, 0xA5 MSB-first; idle low for 232 clocks; ack_error=0.
REQ-028 SHALL cover sda_in=1 during the first ACK with I2C_ACK_CHECK_EN defined -> ack_error=1; STOP follows immediately; idle returns 88 clocks after acceptance.
REQ-029 SHALL cover start pulsed at clock 50 of a transfer, and again on the last STOP clock -> both ignored; only one transaction observed.
REQ-030 SHALL cover 40 idle clocks -> exactly 5 cl_high strobes spaced 8 clocks apart, each lasting one clock.
REQ-031 SHALL cover reset asserted during the 2nd BIT of byte 1 -> scl=1, sda_oe=0, idle=1 on the next clock, with no STOP generated.
REQ-032 SHALL cover START and STOP timing -> SDA falls only while SCL=1 at phase 2 of START, and rises only while SCL=1 at phase 3 of STOP.
